// File: rtl/lfsr_rng_arbiter.sv
// lfsr_rng_arbiter
//   Round-robin scheduler sharing one external 8-bit LFSR among NREQ
//   requesters. A winner gets the LFSR advanced STEPS positions; the
//   resulting byte is returned with a one-cycle one-hot grant pulse.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   req        request lines, bit i = requester i (sampled in IDLE only)
//   gnt        one-hot grant pulse, rnd_data valid while any bit is high
//   rnd_data   random byte for the granted requester, held until next grant
//   busy       grant sequence in progress (STEP/RESP/DONE)
//   lfsr_step  LFSR advance enable, one shift per cycle while high
//   lfsr_val   current LFSR state
//   grant_cnt  (LFSR_ARB_STATS_EN only) 16-bit saturating grant counter
//              per requester, requester i in bits [16i+15:16i]
//
// Build option: define LFSR_ARB_STATS_EN to add grant_cnt.
module lfsr_rng_arbiter #(
  parameter int NREQ  = 4,
  parameter int STEPS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [7:0]      rnd_data,
  output logic            busy,
  output logic            lfsr_step,
  input  logic [7:0]      lfsr_val
`ifdef LFSR_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0] grant_cnt
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, STEP, RESP, DONE} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   win_q, win_d;
  logic [IW-1:0]   last_q, last_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [7:0]      rnd_q, rnd_d;

  // Round-robin pick: scan starting one past the last winner.
  logic          found;
  logic [IW-1:0] pick;
  logic [IW-1:0] cand;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last_q) + k) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;       // grant is a single-cycle pulse
    rnd_d   = rnd_q;
    case (state_q)
      IDLE: if (found) begin
        win_d   = pick;
        last_d  = pick;
        cnt_d   = 4'(STEPS);
        state_d = STEP;
      end
      STEP: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: begin
        // LFSR has absorbed its last shift; capture and announce.
        rnd_d   = lfsr_val;
        gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << win_q;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      win_q   <= '0;
      last_q  <= IW'(NREQ - 1);   // requester 0 gets first priority
      cnt_q   <= '0;
      gnt_q   <= '0;
      rnd_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      rnd_q   <= rnd_d;
    end
  end

  assign gnt       = gnt_q;
  assign rnd_data  = rnd_q;
  assign busy      = (state_q != IDLE);
  assign lfsr_step = (state_q == STEP);

`ifdef LFSR_ARB_STATS_EN
  logic [NREQ-1:0][15:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    for (int i = 0; i < NREQ; i++)
      if (gnt_q[i] && stat_q[i] != 16'hFFFF) stat_d[i] = stat_q[i] + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) stat_q <= '0;
    else       stat_q <= stat_d;
  end

  assign grant_cnt = stat_q;
`endif

endmodule
